param_mem_arbiter: RTL

Two-port to one-port memory arbiter that sits directly downstream of `param_riscv_Core`. It merges the core's instruction and data request ports onto a single memory port and returns each response to the port that issued it, in order. Arbitration is round-robin with grant locking. A tag FIFO tracks up to `P_DEPTH` outstanding requests.

---
 rtl/param_mem_arbiter_pkg.sv | 33 +++
 rtl/param_mem_arbiter_if.sv | 42 ++++
 rtl/param_mem_arbiter_tag.sv | 65 ++++++
 rtl/param_mem_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/param_mem_arbiter_pkg.sv
// Shared definitions for the two-port to one-port memory arbiter: message
// widths, field offsets, port ids and the lock state encoding.
package param_mem_arbiter_pkg;

  localparam int REQ_W  = 67;
  localparam int RESP_W = 35;

  // Request message fields {rw, addr, len, data}
  localparam int REQ_RW_BIT   = 66;
  localparam int REQ_ADDR_LSB = 34;
  localparam int REQ_LEN_LSB  = 32;
  localparam int REQ_DATA_LSB = 0;

  // Response message fields {rw, len, data}
  localparam int RESP_RW_BIT   = 34;
  localparam int RESP_LEN_LSB  = 32;
  localparam int RESP_DATA_LSB = 0;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/param_mem_arbiter_if.sv
// Bundle of the core-side request/response ports and the merged memory port.
// The arbiter takes the slave view; the core/memory environment takes master.
interface param_mem_arbiter_if;
  import param_mem_arbiter_pkg::*;

  logic [REQ_W-1:0]  imemreq_msg;
  logic              imemreq_val;
  logic              imemreq_rdy;
  logic [RESP_W-1:0] imemresp_msg;
  logic              imemresp_val;

  logic [REQ_W-1:0]  dmemreq_msg;
  logic              dmemreq_val;
  logic              dmemreq_rdy;
  logic [RESP_W-1:0] dmemresp_msg;
  logic              dmemresp_val;

  logic [REQ_W-1:0]  memreq_msg;
  logic              memreq_val;
  logic              memreq_rdy;
  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val;

  modport slave (
    input  imemreq_msg, imemreq_val,
    output imemreq_rdy, imemresp_msg, imemresp_val,
    input  dmemreq_msg, dmemreq_val,
    output dmemreq_rdy, dmemresp_msg, dmemresp_val,
    output memreq_msg, memreq_val,
    input  memreq_rdy, memresp_msg, memresp_val
  );

  modport master (
    output imemreq_msg, imemreq_val,
    input  imemreq_rdy, imemresp_msg, imemresp_val,
    output dmemreq_msg, dmemreq_val,
    input  dmemreq_rdy, dmemresp_msg, dmemresp_val,
    input  memreq_msg, memreq_val,
    output memreq_rdy, memresp_msg, memresp_val
  );

endinterface

// File: rtl/param_mem_arbiter_tag.sv
// Tag FIFO: one-bit port ids for outstanding requests, P_DEPTH deep, with
// synchronous push/pop and full/empty/count status.
module param_tag_fifo #(
  parameter int P_DEPTH   = 4,
  parameter int P_PTRBITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               push_data_i,
  input  logic               pop_i,
  output logic               head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [P_PTRBITS:0] count_o
);

  localparam logic [P_PTRBITS:0] FULL_CNT = P_DEPTH[P_PTRBITS:0];

  logic [P_DEPTH-1:0]   mem_q;
  logic [P_PTRBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_PTRBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_PTRBITS:0]   count_q,  count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing pointers and count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/param_mem_arbiter.sv
// Merges the core's instruction and data request ports onto one memory port
// with round-robin grant locking, and routes in-order responses back by tag.
module param_mem_arbiter
  import param_mem_arbiter_pkg::*;
#(
  parameter int P_DEPTH   = 4,
  parameter int P_PTRBITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  param_mem_arbiter_if.slave     bus,
  output logic [P_PTRBITS:0]     count,
  output logic                   err_orphan
);

  lock_state_e state_q,      state_d;
  port_e       lock_port_q,  lock_port_d;
  port_e       last_grant_q, last_grant_d;
  logic        err_q,        err_d;

  port_e grant;
  port_e head;
  logic  head_bit;
  logic  any_val, full, empty;
  logic  accept, pop;

  assign any_val = bus.imemreq_val | bus.dmemreq_val;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = last_grant_q;
    if (state_q == ST_LOCKED)                    grant = lock_port_q;
    else if (bus.imemreq_val && bus.dmemreq_val) grant = other_port(last_grant_q);
    else if (bus.imemreq_val)                    grant = PORT_I;
    else if (bus.dmemreq_val)                    grant = PORT_D;
  end

  // Full blocks the request side even when a pop frees a slot this cycle.
  assign bus.memreq_val  = any_val && !full;
  assign bus.memreq_msg  = (grant == PORT_D) ? bus.dmemreq_msg : bus.imemreq_msg;
  assign bus.imemreq_rdy = bus.memreq_rdy && bus.memreq_val && (grant == PORT_I);
  assign bus.dmemreq_rdy = bus.memreq_rdy && bus.memreq_val && (grant == PORT_D);

  assign accept = bus.memreq_val && bus.memreq_rdy;
  assign pop    = bus.memresp_val && !empty;
  assign head   = port_e'(head_bit);

  assign bus.imemresp_msg = bus.memresp_msg;
  assign bus.dmemresp_msg = bus.memresp_msg;
  assign bus.imemresp_val = pop && (head == PORT_I);
  assign bus.dmemresp_val = pop && (head == PORT_D);

  assign err_orphan = err_q;

  param_tag_fifo #(
    .P_DEPTH   (P_DEPTH),
    .P_PTRBITS (P_PTRBITS)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (accept),
    .push_data_i (grant == PORT_D),
    .pop_i       (pop),
    .head_o      (head_bit),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_comb begin
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (bus.memresp_val && empty);
    unique case (state_q)
      ST_OPEN: begin
        if (bus.memreq_val && !bus.memreq_rdy) begin
          state_d     = ST_LOCKED;
          lock_port_d = grant;
        end
      end
      ST_LOCKED: begin
        if (accept) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
    if (accept) last_grant_d = grant;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_OPEN;
      lock_port_q  <= PORT_I;
      last_grant_q <= PORT_D;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_port_q  <= lock_port_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule
